timestamp_bram_logger: RTL and testbench

Upstream write stage for the BRAM switch: accepts a stream of 64-bit timestamp records and writes them to consecutive words of a BRAM through a native BRAM master port, which feeds one input of the switch. A start/stop control pair comes from AXI4-Lite registers and arms a capture window. Capture either stops when the window is full or wraps as a ring buffer. Status counters and flags go back to the register block.

---
 rtl/efcc_logger_pkg.sv | 18 +
 rtl/timestamp_bram_logger_sat_counter.sv | 26 ++
 rtl/timestamp_bram_logger.sv | 150 +++++++++++++++
 tb/tb_timestamp_bram_logger.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/efcc_logger_pkg.sv
// Shared types and constants for the timestamp BRAM logger: FSM states and
// status-counter width plus its saturation value.
package efcc_logger_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FULL = 2'd2
    } state_t;

    localparam int STAT_WIDTH = 32;
    localparam logic [STAT_WIDTH-1:0] STAT_SAT = '1;

    function automatic logic isSaturated(input logic [STAT_WIDTH-1:0] value);
        return value == STAT_SAT;
    endfunction

endpackage

// File: rtl/timestamp_bram_logger_sat_counter.sv
// Saturating status counter: clear has priority, increments stop at STAT_SAT.
module sat_counter
    import efcc_logger_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_clear,
    input  logic                  i_inc,
    output logic [STAT_WIDTH-1:0] o_count
);

    logic [STAT_WIDTH-1:0] r_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_inc && !isSaturated(r_count)) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_count = r_count;

endmodule

// File: rtl/timestamp_bram_logger.sv
// Captures a stream of timestamp records into consecutive BRAM words through a
// write-only native BRAM port, with start/stop control and ring-buffer option.
module timestamp_bram_logger
    import efcc_logger_pkg::*;
#(
    parameter int BRAMDATA_WIDTH = 64,
    parameter int BRAMADDR_WIDTH = 18
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [BRAMDATA_WIDTH-1:0]   s_axis_tdata,
    input  logic                        s_axis_tvalid,
    output logic                        s_axis_tready,
    input  logic                        cfg_start,
    input  logic                        cfg_stop,
    input  logic                        cfg_wrap,
    input  logic [BRAMADDR_WIDTH-1:0]   cfg_last_addr,
    output logic                        stat_busy,
    output logic                        stat_full,
    output logic                        stat_wrapped,
    output logic [STAT_WIDTH-1:0]       stat_count,
    output logic [STAT_WIDTH-1:0]       stat_drop,
    output logic                        m_clka,
    output logic                        m_rsta,
    output logic [BRAMADDR_WIDTH-1:0]   m_addra,
    output logic [BRAMDATA_WIDTH-1:0]   m_dina,
    output logic                        m_ena,
    output logic [BRAMDATA_WIDTH/8-1:0] m_wea,
    input  logic [BRAMDATA_WIDTH-1:0]   m_douta
);

    localparam int WE_WIDTH = BRAMDATA_WIDTH / 8;

    state_t                      r_state;
    state_t                      w_nextState;
    logic [BRAMADDR_WIDTH-1:0]   r_addr;
    logic [BRAMADDR_WIDTH-1:0]   r_lastAddr;
    logic                        r_wrap;
    logic                        r_full;
    logic                        r_wrapped;
    logic                        r_ena;
    logic [BRAMADDR_WIDTH-1:0]   r_addrOut;
    logic [BRAMDATA_WIDTH-1:0]   r_dinOut;

    logic                        w_start;
    logic                        w_stop;
    logic                        w_accept;
    logic                        w_drop;
    logic                        w_atLast;
    logic                        w_unusedDouta;

    // A simultaneous stop cancels the start entirely, including the latching.
    assign w_stop   = cfg_stop;
    assign w_start  = cfg_start && !cfg_stop;
    assign w_accept = s_axis_tvalid && (r_state == RUN) && !cfg_start && !cfg_stop;
    assign w_drop   = s_axis_tvalid && !w_accept;
    assign w_atLast = (r_addr == r_lastAddr);

    assign w_unusedDouta = ^m_douta;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        if (w_stop) begin
            w_nextState = IDLE;
        end else if (w_start) begin
            w_nextState = RUN;
        end else if (w_accept && w_atLast && !r_wrap) begin
            w_nextState = FULL;
        end
    end

    // In stop-when-full mode the address parks on the last word.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_addr     <= '0;
            r_lastAddr <= '0;
            r_wrap     <= 1'b0;
            r_full     <= 1'b0;
            r_wrapped  <= 1'b0;
        end else if (w_start) begin
            r_addr     <= '0;
            r_lastAddr <= cfg_last_addr;
            r_wrap     <= cfg_wrap;
            r_full     <= 1'b0;
            r_wrapped  <= 1'b0;
        end else if (w_accept) begin
            if (w_atLast) begin
                if (r_wrap) begin
                    r_addr    <= '0;
                    r_wrapped <= 1'b1;
                end else begin
                    r_full    <= 1'b1;
                end
            end else begin
                r_addr <= BRAMADDR_WIDTH'(r_addr + 1'b1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ena     <= 1'b0;
            r_addrOut <= '0;
            r_dinOut  <= '0;
        end else begin
            r_ena <= w_accept;
            if (w_accept) begin
                r_addrOut <= r_addr;
                r_dinOut  <= s_axis_tdata;
            end
        end
    end

    sat_counter u_countCounter (
        .clk     (clk),
        .rst     (rst),
        .i_clear (w_start),
        .i_inc   (w_accept),
        .o_count (stat_count)
    );

    sat_counter u_dropCounter (
        .clk     (clk),
        .rst     (rst),
        .i_clear (1'b0),
        .i_inc   (w_drop),
        .o_count (stat_drop)
    );

    assign s_axis_tready = 1'b1;
    assign stat_busy     = (r_state == RUN);
    assign stat_full     = r_full;
    assign stat_wrapped  = r_wrapped;

    assign m_clka  = clk;
    assign m_rsta  = rst;
    assign m_addra = r_addrOut;
    assign m_dina  = r_dinOut;
    assign m_ena   = r_ena;
    assign m_wea   = {WE_WIDTH{r_ena}};

endmodule

// File: tb/tb_timestamp_bram_logger.sv
// Directed self-checking bench for timestamp_bram_logger with a small BRAM
// model that captures every write for read-back.
module tb_timestamp_bram_logger;

    logic        clk;
    logic        rst;
    logic [63:0] sAxisTdata;
    logic        sAxisTvalid;
    logic        sAxisTready;
    logic        cfgStart;
    logic        cfgStop;
    logic        cfgWrap;
    logic [17:0] cfgLastAddr;
    logic        statBusy;
    logic        statFull;
    logic        statWrapped;
    logic [31:0] statCount;
    logic [31:0] statDrop;
    logic        mClka;
    logic        mRsta;
    logic [17:0] mAddra;
    logic [63:0] mDina;
    logic        mEna;
    logic [7:0]  mWea;
    logic [63:0] mDouta;

    int checks = 0;
    int errors = 0;
    int enaCycles = 0;
    int enaBase;
    logic [63:0] bramModel [0:15];

    timestamp_bram_logger dut (
        .clk           (clk),
        .rst           (rst),
        .s_axis_tdata  (sAxisTdata),
        .s_axis_tvalid (sAxisTvalid),
        .s_axis_tready (sAxisTready),
        .cfg_start     (cfgStart),
        .cfg_stop      (cfgStop),
        .cfg_wrap      (cfgWrap),
        .cfg_last_addr (cfgLastAddr),
        .stat_busy     (statBusy),
        .stat_full     (statFull),
        .stat_wrapped  (statWrapped),
        .stat_count    (statCount),
        .stat_drop     (statDrop),
        .m_clka        (mClka),
        .m_rsta        (mRsta),
        .m_addra       (mAddra),
        .m_dina        (mDina),
        .m_ena         (mEna),
        .m_wea         (mWea),
        .m_douta       (mDouta)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // BRAM model: captures every enabled write, sampled mid-cycle
    always @(negedge clk) begin
        if (mEna && mWea == 8'hFF) begin
            bramModel[mAddra[3:0]] = mDina;
        end
        if (mEna) begin
            enaCycles++;
        end
    end

    function automatic logic [63:0] readBack(input int addr);
        return bramModel[addr];
    endfunction

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not complete in time");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic start, input logic stop, input logic wrap,
                                 input logic [17:0] last, input logic valid,
                                 input logic [63:0] data);
        cfgStart    = start;
        cfgStop     = stop;
        cfgWrap     = wrap;
        cfgLastAddr = last;
        sAxisTvalid = valid;
        sAxisTdata  = data;
        @(posedge clk);
        #1;
        cfgStart    = 1'b0;
        cfgStop     = 1'b0;
        sAxisTvalid = 1'b0;
    endtask

    initial begin
        logic [63:0] wrapExpect [0:3];
        wrapExpect[0] = 64'd5;
        wrapExpect[1] = 64'd6;
        wrapExpect[2] = 64'd3;
        wrapExpect[3] = 64'd4;
        for (int i = 0; i < 16; i++) bramModel[i] = '0;

        rst = 1'b1;
        sAxisTdata = '0;
        sAxisTvalid = 1'b0;
        cfgStart = 1'b0;
        cfgStop = 1'b0;
        cfgWrap = 1'b0;
        cfgLastAddr = '0;
        mDouta = 64'hDEAD_BEEF_0BAD_F00D;

        #2;
        checkOutput("reset tready", 64'(sAxisTready), 64'd1);
        checkOutput("reset busy", 64'(statBusy), 64'd0);
        checkOutput("reset count", 64'(statCount), 64'd0);
        checkOutput("reset drop", 64'(statDrop), 64'd0);
        checkOutput("reset ena", 64'(mEna), 64'd0);
        checkOutput("reset wea", 64'(mWea), 64'd0);
        checkOutput("reset rsta", 64'(mRsta), 64'd1);
        @(negedge clk);
        rst = 1'b0;
        applyStimulus(0, 0, 0, 18'd0, 0, 64'd0);

        $display("[TB] idle drop");
        for (int i = 0; i < 5; i++) begin
            applyStimulus(0, 0, 0, 18'd0, 1, 64'(50 + i));
            checkOutput("idle no write", 64'(mEna), 64'd0);
        end
        checkOutput("idle drop count", 64'(statDrop), 64'd5);
        applyStimulus(1, 1, 1, 18'd5, 0, 64'd0);
        checkOutput("start+stop busy", 64'(statBusy), 64'd0);
        checkOutput("start+stop count", 64'(statCount), 64'd0);
        applyStimulus(0, 0, 0, 18'd0, 1, 64'd77);
        checkOutput("start+stop stays idle", 64'(statDrop), 64'd6);

        $display("[TB] base capture");
        applyStimulus(1, 0, 0, 18'd7, 0, 64'd0);
        checkOutput("base busy", 64'(statBusy), 64'd1);
        enaBase = enaCycles;
        for (int i = 0; i < 10; i++) begin
            applyStimulus(0, 0, 0, 18'd7, 1, 64'(100 + i));
            if (i < 8) begin
                checkOutput("base ena", 64'(mEna), 64'd1);
                checkOutput("base wea", 64'(mWea), 64'hFF);
                checkOutput("base addr", 64'(mAddra), 64'(i));
                checkOutput("base data", mDina, 64'(100 + i));
            end else begin
                checkOutput("base ena after full", 64'(mEna), 64'd0);
            end
            if (i == 7) begin
                checkOutput("base full edge", 64'(statFull), 64'd1);
                checkOutput("base busy edge", 64'(statBusy), 64'd0);
            end
        end
        applyStimulus(0, 0, 0, 18'd0, 0, 64'd0);
        checkOutput("base count", 64'(statCount), 64'd8);
        checkOutput("base full", 64'(statFull), 64'd1);
        checkOutput("base busy", 64'(statBusy), 64'd0);
        checkOutput("base drop", 64'(statDrop), 64'd8);
        checkOutput("base ena cycles", 64'(enaCycles - enaBase), 64'd8);
        for (int a = 0; a < 8; a++) begin
            checkOutput("base readback", readBack(a), 64'(100 + a));
        end

        $display("[TB] wrap capture");
        applyStimulus(1, 0, 1, 18'd3, 0, 64'd0);
        checkOutput("wrap cleared full", 64'(statFull), 64'd0);
        for (int i = 0; i < 6; i++) begin
            applyStimulus(0, 0, 1, 18'd3, 1, 64'(i + 1));
            checkOutput("wrap addr", 64'(mAddra), 64'(i % 4));
            checkOutput("wrap data", mDina, 64'(i + 1));
        end
        applyStimulus(0, 0, 0, 18'd0, 0, 64'd0);
        checkOutput("wrap wrapped", 64'(statWrapped), 64'd1);
        checkOutput("wrap count", 64'(statCount), 64'd6);
        checkOutput("wrap no drop", 64'(statDrop), 64'd8);
        checkOutput("wrap busy", 64'(statBusy), 64'd1);
        for (int a = 0; a < 4; a++) begin
            checkOutput("wrap readback", readBack(a), wrapExpect[a]);
        end

        $display("[TB] restart");
        applyStimulus(1, 0, 0, 18'd3, 0, 64'd0);
        checkOutput("restart wrapped cleared", 64'(statWrapped), 64'd0);
        applyStimulus(0, 0, 0, 18'd3, 1, 64'd200);
        applyStimulus(0, 0, 0, 18'd3, 1, 64'd201);
        checkOutput("restart first addr", 64'(mAddra), 64'd1);
        applyStimulus(1, 0, 0, 18'd1, 0, 64'd0);
        checkOutput("restart count cleared", 64'(statCount), 64'd0);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(0, 0, 0, 18'd1, 1, 64'(300 + i));
            if (i < 2) begin
                checkOutput("restart addr", 64'(mAddra), 64'(i));
                checkOutput("restart data", mDina, 64'(300 + i));
            end else begin
                checkOutput("restart dropped no write", 64'(mEna), 64'd0);
            end
        end
        checkOutput("restart count", 64'(statCount), 64'd2);
        checkOutput("restart full", 64'(statFull), 64'd1);
        checkOutput("restart drop", 64'(statDrop), 64'd9);
        checkOutput("restart readback0", readBack(0), 64'd300);
        checkOutput("restart readback1", readBack(1), 64'd301);

        $display("[TB] stop after acceptance");
        applyStimulus(1, 0, 0, 18'd7, 0, 64'd0);
        applyStimulus(0, 0, 0, 18'd7, 1, 64'd400);
        cfgStop = 1'b1;
        #1;
        checkOutput("stop pending ena", 64'(mEna), 64'd1);
        checkOutput("stop pending data", mDina, 64'd400);
        @(posedge clk);
        #1;
        cfgStop = 1'b0;
        checkOutput("stop busy", 64'(statBusy), 64'd0);
        checkOutput("stop count", 64'(statCount), 64'd1);
        checkOutput("stop ena done", 64'(mEna), 64'd0);

        $display("[TB] reset mid-stream");
        applyStimulus(1, 0, 1, 18'd7, 0, 64'd0);
        applyStimulus(0, 0, 1, 18'd7, 1, 64'd500);
        checkOutput("pre-reset ena", 64'(mEna), 64'd1);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("mid reset ena", 64'(mEna), 64'd0);
        checkOutput("mid reset wea", 64'(mWea), 64'd0);
        checkOutput("mid reset busy", 64'(statBusy), 64'd0);
        checkOutput("mid reset count", 64'(statCount), 64'd0);
        checkOutput("mid reset drop", 64'(statDrop), 64'd0);
        checkOutput("mid reset full", 64'(statFull), 64'd0);
        checkOutput("mid reset wrapped", 64'(statWrapped), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        applyStimulus(0, 0, 0, 18'd0, 1, 64'd600);
        checkOutput("post reset busy", 64'(statBusy), 64'd0);
        checkOutput("post reset no write", 64'(mEna), 64'd0);
        checkOutput("post reset drop", 64'(statDrop), 64'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
